// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary.
// Widths here are the defaults used by regfile and reg_read_stage.
package pipe_pkg;

    localparam int XLEN      = 64;
    localparam int CTRL_W    = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rs1;
        reg_idx_t          rs2;
        reg_idx_t          rd;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   data1;
        logic [XLEN-1:0]   data2;
    } idex_t;

endpackage

// File: rtl/regfile.sv
// 32xXLEN integer register file, 2 async reads, 1 sync write, x0 hardwired.
// WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module regfile
    import pipe_pkg::*;
#(
    parameter int XLEN = pipe_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  reg_idx_t        ra1,
    input  reg_idx_t        ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  reg_idx_t        wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[ra1];
`ifdef WB_BYPASS_EN
        if (we && wa == ra1) rd1 = wd;
`endif
        if (ra1 == '0) rd1 = '0;
    end

    always_comb begin
        rd2 = mem[ra2];
`ifdef WB_BYPASS_EN
        if (we && wa == ra2) rd2 = wd;
`endif
        if (ra2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: regfile, load-use bubble, ID/EX register, bubble counter.
// Optional WB_BYPASS_EN: write-through regfile instead of holding on a same-cycle writeback.
module reg_read_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_is_load,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [XLEN-1:0]   out_data1,
    output logic [XLEN-1:0]   out_data2,
    output logic [4:0]        out_rd,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       bubble_cnt
);

    idex_t           idex_q;
    idex_t           idex_d;
    logic            valid_q;
    logic [31:0]     bub_q;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            hazard;
    logic            wb_hold;
    logic            advance;
    logic            in_fire;
    logic            dep1;
    logic            dep2;

    regfile #(.XLEN(XLEN)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (in_rs1),
        .ra2   (in_rs2),
        .rd1   (rdata1),
        .rd2   (rdata2),
        .we    (wb_we),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    assign dep1 = in_rs1 == idex_q.rd && in_rs1 != '0;
    assign dep2 = in_rs2 == idex_q.rd && in_rs2 != '0;

    assign hazard = valid_q && idex_q.is_load
                 && idex_q.rd != '0 && (dep1 || dep2);

`ifdef WB_BYPASS_EN
    assign wb_hold = 1'b0;
`else
    // Reads see the old value on a same-cycle write; wait for it to land.
    assign wb_hold = wb_we && wb_rd != '0
                  && (in_rs1 == wb_rd || in_rs2 == wb_rd);
`endif

    assign advance  = !valid_q || out_ready;
    assign in_ready = !flush && !hazard && !wb_hold && advance;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        idex_d         = idex_q;
        idex_d.rs1     = in_rs1;
        idex_d.rs2     = in_rs2;
        idex_d.rd      = in_rd;
        idex_d.is_load = in_is_load;
        idex_d.ctrl    = in_ctrl;
        idex_d.data1   = rdata1;
        idex_d.data2   = rdata2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= in_fire;
            if (in_fire) idex_q <= idex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bub_q <= '0;
        end else if (in_valid && hazard && out_ready && !flush
                     && bub_q != 32'hFFFF_FFFF) begin
            bub_q <= bub_q + 32'd1;
        end
    end

    assign out_valid   = valid_q;
    assign out_rs1     = idex_q.rs1;
    assign out_rs2     = idex_q.rs2;
    assign out_rd      = idex_q.rd;
    assign out_is_load = idex_q.is_load;
    assign out_ctrl    = idex_q.ctrl;
    assign out_data1   = idex_q.data1;
    assign out_data2   = idex_q.data2;
    assign bubble_cnt  = bub_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage; expected ID/EX payloads are queued
// on acceptance and compared when the stage presents them.
module tb_reg_read_stage;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic              in_is_load;
    logic [CTRL_W-1:0] in_ctrl;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [XLEN-1:0]   out_data1;
    logic [XLEN-1:0]   out_data2;
    logic [4:0]        out_rd;
    logic              out_is_load;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       bubble_cnt;

    int              vectors = 0;
    int              errors  = 0;
    int              exp_bub = 0;
    idex_t           sb[$];
    logic [XLEN-1:0] model_rf [32];

    reg_read_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_is_load  (in_is_load),
        .in_ctrl     (in_ctrl),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_data1   (out_data1),
        .out_data2   (out_data2),
        .out_rd      (out_rd),
        .out_is_load (out_is_load),
        .out_ctrl    (out_ctrl),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic idex_t got_out();
        idex_t g;
        g.rs1     = out_rs1;
        g.rs2     = out_rs2;
        g.rd      = out_rd;
        g.is_load = out_is_load;
        g.ctrl    = out_ctrl;
        g.data1   = out_data1;
        g.data2   = out_data2;
        return g;
    endfunction

    function automatic logic [XLEN-1:0] mrd(input logic [4:0] a);
        return (a == 5'd0) ? '0 : model_rf[a];
    endfunction

    function automatic idex_t mk(input logic [4:0] rs1,
                                 input logic [4:0] rs2,
                                 input logic [4:0] rd,
                                 input logic ld,
                                 input logic [CTRL_W-1:0] c);
        idex_t e;
        e.rs1     = rs1;
        e.rs2     = rs2;
        e.rd      = rd;
        e.is_load = ld;
        e.ctrl    = c;
        e.data1   = mrd(rs1);
        e.data2   = mrd(rs2);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [XLEN-1:0] d);
        wb_we   = 1'b1;
        wb_rd   = r;
        wb_data = d;
        tick();
        wb_we = 1'b0;
        if (r != 5'd0) model_rf[r] = d;
    endtask

    // Presents one instruction, waits (bounded) for acceptance, queues expectation.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic ld,
                         input logic [CTRL_W-1:0] c);
        bit ok = 0;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_is_load = ld;
        in_ctrl    = c;
        in_valid   = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (in_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_accept: in_ready stuck at 0, need 1");
        end else begin
            sb.push_back(mk(rs1, rs2, rd, ld, c));
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop_cmp(input string nm);
        idex_t e;
        idex_t g;
        vectors++;
        if (!out_valid || sb.size() == 0) begin
            errors++;
            $display("FAIL %s: out_valid=%0b queued=%0d, need valid entry",
                     nm, out_valid, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            g = got_out();
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h, need %h", nm, g, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || bubble_cnt !== 32'd0
            || got_out() !== idex_t'(0)) begin
            errors++;
            $display("FAIL reset: valid=%b bub=%0d out=%h, need all 0",
                     out_valid, bubble_cnt, got_out());
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, need 1", in_ready);
        end
    endtask

    task automatic test_wb_read();
        wb_write(5'd5, 64'hDEAD);
        issue(5'd5, 5'd0, 5'd1, 1'b0, 32'hA5A5_0001);
        pop_cmp("wb_read");
        idle(1);
    endtask

    task automatic do_load_use(input logic [4:0] r, input logic [XLEN-1:0] v);
        wb_write(r, v);
        idle(1);
        issue(5'd5, 5'd0, r, 1'b1, 32'h0000_0100);
        in_rs1   = 5'd0;
        in_rs2   = r;
        in_rd    = 5'd3;
        in_is_load = 1'b0;
        in_ctrl  = 32'h0000_0200;
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: in_ready=%b, need 0", in_ready);
        end
        pop_cmp("load_use_load");
        tick();
        exp_bub++;
        vectors++;
        if (out_valid !== 1'b0 || bubble_cnt !== 32'(exp_bub)) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%b bub=%0d, need 0/%0d",
                     out_valid, bubble_cnt, exp_bub);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: in_ready=%b, need 1", in_ready);
        end
        sb.push_back(mk(5'd0, r, 5'd3, 1'b0, 32'h0000_0200));
        tick();
        in_valid = 1'b0;
        pop_cmp("load_use_dep");
        idle(1);
    endtask

    task automatic test_load_use();
        do_load_use(5'd7, 64'h7777_0000_0000_0007);
    endtask

    task automatic test_wb_same_cycle();
        wb_we      = 1'b1;
        wb_rd      = 5'd9;
        wb_data    = 64'h1234;
        model_rf[9] = 64'h1234;
        in_rs1     = 5'd9;
        in_rs2     = 5'd5;
        in_rd      = 5'd4;
        in_is_load = 1'b0;
        in_ctrl    = 32'hC0DE_0003;
        in_valid   = 1'b1;
        #1;
        vectors++;
`ifdef WB_BYPASS_EN
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wb_bypass_ready: in_ready=%b, need 1", in_ready);
        end
`else
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL wb_hold_ready: in_ready=%b, need 0", in_ready);
        end
        tick();
        wb_we = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wb_hold_release: in_ready=%b, need 1", in_ready);
        end
`endif
        sb.push_back(mk(5'd9, 5'd5, 5'd4, 1'b0, 32'hC0DE_0003));
        tick();
        wb_we    = 1'b0;
        in_valid = 1'b0;
        pop_cmp("wb_same_cycle");
        idle(1);
    endtask

    task automatic test_x0();
        wb_write(5'd0, 64'hFFFF);
        issue(5'd0, 5'd0, 5'd2, 1'b0, 32'h0000_0004);
        pop_cmp("x0_read");
        idle(1);
        issue(5'd9, 5'd0, 5'd0, 1'b1, 32'h0000_0005);
        in_rs1   = 5'd0;
        in_rs2   = 5'd0;
        in_rd    = 5'd6;
        in_ctrl  = 32'h0000_0006;
        in_is_load = 1'b0;
        in_valid = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_no_hazard: in_ready=%b, need 1", in_ready);
        end
        pop_cmp("x0_load");
        sb.push_back(mk(5'd0, 5'd0, 5'd6, 1'b0, 32'h0000_0006));
        tick();
        in_valid = 1'b0;
        pop_cmp("x0_dep");
        vectors++;
        if (bubble_cnt !== 32'(exp_bub)) begin
            errors++;
            $display("FAIL x0_bubbles: bub=%0d, need %0d", bubble_cnt, exp_bub);
        end
        idle(1);
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        issue(5'd5, 5'd7, 5'd8, 1'b0, 32'h5A5A_0007);
        in_rs1   = 5'd3;
        in_rs2   = 5'd0;
        in_rd    = 5'd10;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || sb.size() == 0 || got_out() !== sb[0]) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rdy=%b vld=%b out=%h",
                         i, in_ready, out_valid, got_out());
            end
            tick();
        end
        flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b, need 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: out_valid=%b, need 0", out_valid);
        end
        out_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_reset_mid();
        do_load_use(5'd11, 64'hBB);
        do_load_use(5'd12, 64'hCC);
        vectors++;
        if (bubble_cnt !== 32'd3) begin
            errors++;
            $display("FAIL bubbles3: bub=%0d, need 3", bubble_cnt);
        end
        out_ready = 1'b0;
        issue(5'd5, 5'd0, 5'd7, 1'b1, 32'h0000_0009);
        in_rs1   = 5'd7;
        in_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        exp_bub = 0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b bub=%0d, need 0/0",
                     out_valid, bubble_cnt);
        end
        issue(5'd5, 5'd7, 5'd1, 1'b0, 32'h0000_000A);
        pop_cmp("reset_regs_zero");
        idle(1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_rd      = '0;
        in_is_load = 1'b0;
        in_ctrl    = '0;
        wb_we      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        test_reset();
        test_wb_read();
        test_load_use();
        test_wb_same_cycle();
        test_x0();
        test_stall_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
